ifu_next_pc: RTL and testbench
==============================

Name: ifu_next_pc

Overview:
- Instruction-fetch next-PC unit of the RV32/RV64 core; `XLEN` comes from the common defines.
- Computes the next program counter combinationally from the current PC, the jump/branch decode, and the branch comparator flags.
- Also holds a registered copy of the selected next PC, used by fetch when no external PC register is present.
- Sits between decode/ALU (which supply immediates, `alu_out` and flags) and the instruction memory address port.

Parameters:
- XLEN, default `XLEN (32), datapath width.
- RESET_VEC, default 0, value loaded into pc_q on reset.

Ports:
- clk  input  1  core clock; rising edge active.
- rstl  input  1  asynchronous, active-high reset (codebase name kept); affects pc_q only.
- is_branch  input  1  current instruction is a conditional branch.
- is_jmp  input  1  current instruction is JAL or JALR.
- jmp_reg  input  1  with is_jmp: 1 = JALR (register target), 0 = JAL.
- eq  input  1  comparator: rs1 == rs2.
- lt  input  1  comparator: signed rs1 < rs2.
- ltu  input  1  comparator: unsigned rs1 < rs2.
- fn3  input  3  funct3 of the branch instruction.
- alu_out  input  XLEN  ALU result; the JALR target.
- b_imm  input  XLEN  sign-extended B-type immediate.
- j_imm  input  XLEN  sign-extended J-type immediate.
- pc  input  XLEN  PC of the current instruction.
- pc_ifu  output  XLEN  next PC (combinational).
- pc_q  output  XLEN  registered next PC.
- taken  output  1  redirect indicator: jump, or branch with condition true (combinational).

Behaviour:
- pc_ifu is purely combinational, with zero latency from any input. It does not depend on rstl or clk.
- Selection priority:
  - is_jmp=1, jmp_reg=1: pc_ifu = alu_out. No LSB masking here; the ALU/decoder clears bit 0.
  - is_jmp=1, jmp_reg=0: pc_ifu = pc + j_imm.
  - else is_branch=1 and condition true: pc_ifu = pc + b_imm.
  - else: pc_ifu = pc + 4.
- is_jmp overrides is_branch when both are set.
- Branch condition by fn3:
  - 000 BEQ: eq
  - 001 BNE: !eq
  - 100 BLT: lt
  - 101 BGE: !lt
  - 110 BLTU: ltu
  - 111 BGEU: !ltu
  - 010 and 011: condition false (fall through to pc + 4).
- Arithmetic is XLEN-bit two's complement and wraps modulo 2^XLEN, e.g. pc = FFFF_FFFC gives pc+4 = 0. Negative immediates subtract.
- Flag inputs are ignored when is_branch=0. Immediates are ignored unless their path is selected.
- taken = is_jmp | (is_branch & cond).
- pc_q:
  - Asynchronous reset: on rstl rising (or while rstl=1), pc_q = RESET_VEC immediately.
  - Otherwise pc_q <= pc_ifu on each rising clk.
  - If reset is released coincident with a clk edge, pc_q stays RESET_VEC for that edge.

Decomposition:
- Shared package/defines: XLEN; funct3 branch encodings (F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU); RESET_VEC default.
- One sub-module is natural: branch_cond (fn3, eq, lt, ltu -> cond).
- Adders and mux stay in the top module.

Test Plan:
- No jump/branch, pc=0x1000 -> pc_ifu=0x1004, taken=0. Also pc=0xFFFF_FFFC -> pc_ifu=0.
- JAL, pc=0x1000:
  - j_imm=0x20 -> 0x1020.
  - j_imm=-0x20 -> 0x0FE0.
- JALR, alu_out=0x1234_5679 -> pc_ifu=0x1234_5679 (bit 0 not cleared); pc and j_imm have no effect.
- Branches, pc=0x1000, b_imm=±0x40:
  - For each fn3 000/001/100/101/110/111, set the flag to its "not taken" value -> 0x1004.
  - Set it to its "taken" value -> 0x1040 and 0x0FC0 respectively.
  - fn3=010 with any flags -> 0x1004.
- Priority: is_jmp=1 and is_branch=1 with condition true, j_imm=8, b_imm=0x40, pc=0 -> pc_ifu=8.
- Register path:
  - Assert rstl mid-cycle -> pc_q=RESET_VEC without a clk edge.
  - Release rstl; with pc=0x100 and no jump, next clk -> pc_q=0x104.

Source files
------------

// File: rtl/ifu_next_pc_pkg.sv
// Shared definitions for the instruction-fetch next-PC unit: datapath width,
// branch funct3 encodings and the default reset vector.
package ifu_next_pc_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [63:0] RESET_VEC_DEF = 64'h0;

    // Next-PC source, in decreasing priority order
    typedef enum logic [1:0] {
        SEL_JALR   = 2'd0,
        SEL_JAL    = 2'd1,
        SEL_BRANCH = 2'd2,
        SEL_SEQ    = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/ifu_next_pc_branch_cond.sv
// Branch condition decoder: maps funct3 and comparator flags to a taken/not-taken
// decision. Reserved encodings (010, 011) never take.
module ifu_next_pc_branch_cond
    import ifu_next_pc_pkg::*;
(
    input  logic [2:0] fn3,
    input  logic       eq,
    input  logic       lt,
    input  logic       ltu,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (fn3)
            F3_BEQ:  cond = eq;
            F3_BNE:  cond = ~eq;
            F3_BLT:  cond = lt;
            F3_BGE:  cond = ~lt;
            F3_BLTU: cond = ltu;
            F3_BGEU: cond = ~ltu;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ifu_next_pc.sv
// Next-PC selection for instruction fetch: jump/branch/sequential mux with a
// registered copy of the selected address for fetch paths without a PC register.
module ifu_next_pc
    import ifu_next_pc_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEF[XLEN-1:0]
) (
    input  logic            clk,
    input  logic            rstl,
    input  logic            is_branch,
    input  logic            is_jmp,
    input  logic            jmp_reg,
    input  logic            eq,
    input  logic            lt,
    input  logic            ltu,
    input  logic [2:0]      fn3,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] b_imm,
    input  logic [XLEN-1:0] j_imm,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_ifu,
    output logic [XLEN-1:0] pc_q,
    output logic            taken
);

    logic            cond;
    logic            br_taken;
    pc_sel_e         pc_sel;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] pc_jal;
    logic [XLEN-1:0] pc_br;

    ifu_next_pc_branch_cond u_branch_cond (
        .fn3  (fn3),
        .eq   (eq),
        .lt   (lt),
        .ltu  (ltu),
        .cond (cond)
    );

    // Plain modular adders; wraparound past the top of the address space is intended
    assign pc_seq = pc + XLEN'(4);
    assign pc_jal = pc + j_imm;
    assign pc_br  = pc + b_imm;

    assign br_taken = is_branch & cond;
    assign taken    = is_jmp | br_taken;

    always_comb begin
        pc_sel = SEL_SEQ;
        if (is_jmp) begin
            pc_sel = jmp_reg ? SEL_JALR : SEL_JAL;
        end else if (br_taken) begin
            pc_sel = SEL_BRANCH;
        end
    end

    // JALR target is used as-is; bit 0 is cleared upstream
    always_comb begin
        pc_ifu = pc_seq;
        case (pc_sel)
            SEL_JALR:   pc_ifu = alu_out;
            SEL_JAL:    pc_ifu = pc_jal;
            SEL_BRANCH: pc_ifu = pc_br;
            default:    pc_ifu = pc_seq;
        endcase
    end

    always_ff @(posedge clk or posedge rstl) begin
        if (rstl) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_ifu;
        end
    end

endmodule

// File: tb/tb_ifu_next_pc.sv
// Directed testbench for ifu_next_pc: combinational next-PC selection, branch
// conditions, priority, wraparound and the asynchronously reset PC register.
module tb_ifu_next_pc;

    localparam logic [31:0] RV = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rstl;
    logic        is_branch, is_jmp, jmp_reg;
    logic        eq, lt, ltu;
    logic [2:0]  fn3;
    logic [31:0] alu_out, b_imm, j_imm, pc;
    logic [31:0] pc_ifu, pc_q;
    logic        taken;

    int total = 0;
    int bad   = 0;

    ifu_next_pc #(.XLEN(32), .RESET_VEC(RV)) dut (
        .clk       (clk),
        .rstl      (rstl),
        .is_branch (is_branch),
        .is_jmp    (is_jmp),
        .jmp_reg   (jmp_reg),
        .eq        (eq),
        .lt        (lt),
        .ltu       (ltu),
        .fn3       (fn3),
        .alu_out   (alu_out),
        .b_imm     (b_imm),
        .j_imm     (j_imm),
        .pc        (pc),
        .pc_ifu    (pc_ifu),
        .pc_q      (pc_q),
        .taken     (taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: %08h", tag, obs);
        end
    endtask

    task automatic clear_ctl();
        is_branch = 0; is_jmp = 0; jmp_reg = 0;
        eq = 0; lt = 0; ltu = 0; fn3 = 3'b000;
        alu_out = 32'hDEAD_BEEF; b_imm = 32'h0000_0040; j_imm = 32'h0000_0020;
    endtask

    // Drive the flag a condition looks at to v, and the other two flags to ~v
    task automatic set_flags(input int which, input logic v);
        eq  = (which == 0) ? v : ~v;
        lt  = (which == 1) ? v : ~v;
        ltu = (which == 2) ? v : ~v;
    endtask

    logic [2:0] f3s [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    int         fls [6] = '{0, 0, 1, 1, 2, 2};
    logic       nts [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rstl = 0;
        clear_ctl();
        pc = 32'h0000_1000;

        // Reset asserted between clock edges must take effect immediately
        #2 rstl = 1;
        #1 check("reset_async", pc_q, RV);

        #1 check("seq_pc", pc_ifu, 32'h0000_1004);
        check("seq_taken", {31'b0, taken}, 32'h0);
        pc = 32'hFFFF_FFFC;
        #1 check("seq_wrap", pc_ifu, 32'h0000_0000);

        pc = 32'h0000_1000; is_jmp = 1; jmp_reg = 0;
        j_imm = 32'h0000_0020;
        #1 check("jal_pos", pc_ifu, 32'h0000_1020);
        check("jal_taken", {31'b0, taken}, 32'h1);
        j_imm = 32'hFFFF_FFE0;
        #1 check("jal_neg", pc_ifu, 32'h0000_0FE0);

        jmp_reg = 1; alu_out = 32'h1234_5679;
        #1 check("jalr", pc_ifu, 32'h1234_5679);
        pc = 32'h0000_7000; j_imm = 32'h0000_0100;
        #1 check("jalr_ignore_pc", pc_ifu, 32'h1234_5679);

        clear_ctl();
        pc = 32'h0000_1000; is_branch = 1;
        for (int i = 0; i < 6; i++) begin
            fn3 = f3s[i];
            b_imm = 32'h0000_0040;
            set_flags(fls[i], nts[i]);
            #1 check($sformatf("br%0d_nt", i), pc_ifu, 32'h0000_1004);
            check($sformatf("br%0d_nt_taken", i), {31'b0, taken}, 32'h0);
            set_flags(fls[i], ~nts[i]);
            #1 check($sformatf("br%0d_t_pos", i), pc_ifu, 32'h0000_1040);
            check($sformatf("br%0d_t_taken", i), {31'b0, taken}, 32'h1);
            b_imm = 32'hFFFF_FFC0;
            #1 check($sformatf("br%0d_t_neg", i), pc_ifu, 32'h0000_0FC0);
        end

        fn3 = 3'b010;
        for (int f = 0; f < 8; f++) begin
            {eq, lt, ltu} = f[2:0];
            #1 check($sformatf("br_rsv010_f%0d", f), pc_ifu, 32'h0000_1004);
        end
        fn3 = 3'b011; {eq, lt, ltu} = 3'b111;
        #1 check("br_rsv011", pc_ifu, 32'h0000_1004);

        // Branch flags are ignored when no branch is decoded
        is_branch = 0; fn3 = 3'b000; eq = 1;
        #1 check("nobr_flags", pc_ifu, 32'h0000_1004);

        // Jump outranks a taken branch
        pc = 32'h0; is_branch = 1; fn3 = 3'b000; eq = 1;
        is_jmp = 1; jmp_reg = 0; j_imm = 32'h8; b_imm = 32'h40;
        #1 check("prio_jmp", pc_ifu, 32'h0000_0008);
        check("reset_hold", pc_q, RV);

        // Register path
        clear_ctl();
        @(negedge clk);
        rstl = 0;
        pc = 32'h0000_0100;
        @(negedge clk);
        check("pcq_seq", pc_q, 32'h0000_0104);
        is_jmp = 1; pc = 32'h0000_1000; j_imm = 32'h0000_0020;
        @(negedge clk);
        check("pcq_jal", pc_q, 32'h0000_1020);
        #2 rstl = 1;
        #1 check("pcq_reset_mid", pc_q, RV);
        @(negedge clk);
        check("pcq_reset_held", pc_q, RV);
        rstl = 0;
        clear_ctl(); pc = 32'h0000_0200;
        @(negedge clk);
        check("pcq_after_rel", pc_q, 32'h0000_0204);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
